keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Scans a 4x4 hex keypad matrix, debounces each key press and release, and reports each new key as a 4-bit hex code with a one-cycle valid pulse.
- Sits at the input side of the lab design. Its key/key_valid outputs feed the digit registers that drive the dual seven-segment time-multiplexer.
- Scan timing uses the same fractional-increment tick scheme as the display multiplexer.

Parameters:
- P, 1, tick counter increment added every clk.
- N, 16, tick counter width; one scan tick per N-bit counter overflow.
- DB_TICKS, 4, consecutive stable ticks required to accept a press or a release (>=1).

Ports:
- clk  input  1  system clock
- rstn  input  1  asynchronous active-low reset
- rows  input  4  keypad row sense, active-low (pulled up externally), asynchronous to clk
- cols  output  4  column drive, active-low, exactly one bit low at all times
- key  output  4  hex code of last accepted key
- key_valid  output  1  one-cycle pulse when key updates
- pressed  output  1  high while an accepted key is held (HELD or RELEASE state)

Behaviour:
- Reset is asynchronous, active-low, and applies to all flops. Reset values:
  - count=0, col_idx=0, state=SCAN, db_cnt=0
  - cols=4'b1110, key=4'h0, key_valid=0, pressed=0
  - synchronizer flops = 4'b1111
- Synchronizer: rows passes through 2 flops to give rows_s; all decisions use rows_s.
- Tick generation: count <= count + P (mod 2^N) every clk. tick=1 in the cycle where the N-bit add carries out.
- Column drive: cols = ~(4'b0001 << col_idx). col_idx changes only on a tick in SCAN.
- Key map as [row][col]:
  - row0 = 1,2,3,A
  - row1 = 4,5,6,B
  - row2 = 7,8,9,C
  - row3 = E,0,F,D
- FSM (all transitions are evaluated on tick cycles only):
  - SCAN:
    - If any rows_s bit is low: latch row_idx = lowest-index low row; column stays; db_cnt=0; go to DEBOUNCE.
    - Else: col_idx <= col_idx+1 (wraps 3->0).
  - DEBOUNCE:
    - If rows_s[row_idx] is low: db_cnt++. When db_cnt reaches DB_TICKS-1 on a low sample, set key <= map[row_idx][col_idx], assert key_valid for exactly that clk, go to HELD.
    - If rows_s[row_idx] is high: go to SCAN with col_idx+1. No output change.
  - HELD:
    - pressed=1; column stays fixed; other rows are ignored.
    - If rows_s[row_idx] is high: db_cnt=0, go to RELEASE.
  - RELEASE:
    - pressed=1.
    - If rows_s[row_idx] is high: db_cnt++. When it reaches DB_TICKS-1, go to SCAN with col_idx+1.
    - If rows_s[row_idx] is low: db_cnt=0, go to HELD. No new key_valid.
- DB_TICKS=1: press accepted on the first tick in DEBOUNCE; release accepted on the first high tick in RELEASE.
- key holds its value until the next accepted press. key_valid is never high for 2 consecutive clks.
- Multiple keys in the same column: lowest row wins.
- A second key pressed while one is held produces no output. After the first key is released, SCAN finds the second key and reports it as a new press after debounce.
- Reset asserted mid-debounce or mid-hold: immediate return to reset values, with no key_valid.
- Latency from a stable press in the scanned column: 2 clk of synchronizer, then up to 1 tick to enter DEBOUNCE, then DB_TICKS ticks, then key_valid.

Test Plan (P=1, N=2 so tick every 4 clk, DB_TICKS=3):
1. Reset with no keys: cols cycles 1110->1101->1011->0111->1110 every 4 clk; key=0; key_valid never asserts.
2. Press row1/col2 steadily, then release: exactly one key_valid pulse with key=4'h6; pressed=1 until 3 high ticks after release; scanning then resumes from col3.
3. Press row3/col1 bouncing (low 1 tick, high 1 tick, repeated 5 times), then stable: no key_valid during bounce; once stable, single pulse with key=4'h0.
4. Hold row0/col0 (key 1), add row2/col3 (C), release 1: pulse key=1; no pulse while both are down; after release debounce, pulse key=4'hC.
5. Hold row1 and row2 in col0 together: single pulse with key=4'h4 (lowest row wins).
6. Assert rstn low during DEBOUNCE and during HELD: all outputs return to reset values asynchronously; no key_valid pulse after rstn is released unless the press is re-debounced.

Source files
------------

// File: rtl/keypad_scanner_if.sv
// Keypad matrix pins plus the decoded key stream toward the digit registers.
// Latency: n/a (wiring only).
// Backpressure: none; key_valid is a one-cycle pulse the consumer must take.
interface keypad_scanner_if;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [3:0] key;
    logic       key_valid;
    logic       pressed;

    modport master (
        input  rows,
        output cols,
        output key,
        output key_valid,
        output pressed
    );

    modport slave (
        output rows,
        input  cols,
        input  key,
        input  key_valid,
        input  pressed
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner with per-key press/release debounce and hex encode.
// Latency: 2 clk sync + up to 1 tick to lock a column + DB_TICKS ticks to key_valid.
// Backpressure: none; key_valid pulses for one clk and key holds until the next press.
module keypad_scanner #(
    parameter int unsigned P        = 1,
    parameter int unsigned N        = 16,
    parameter int unsigned DB_TICKS = 4
) (
    input  logic           clk,
    input  logic           rstn,
    keypad_scanner_if.master kp
);

    localparam int unsigned DBW = (DB_TICKS > 1) ? $clog2(DB_TICKS) : 1;
    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_TICKS - 1);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t         state, state_n;
    logic [3:0]     rows_m, rows_s;
    logic [N-1:0]   count;
    logic [N:0]     sum;
    logic           tick;
    logic [1:0]     col_idx, col_n;
    logic [1:0]     row_idx, row_n;
    logic [1:0]     low_row;
    logic           any_low;
    logic           row_low;
    logic [DBW-1:0] db_cnt, db_n;
    logic [3:0]     key_r, key_n;
    logic           kv_r, kv_n;

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        case ({r, c})
            4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
            4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
            4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
            4'hC: k = 4'hE;  4'hD: k = 4'h0;  4'hE: k = 4'hF;  default: k = 4'hD;
        endcase
        return k;
    endfunction

    // Fractional tick: the carry out of the N-bit accumulator marks a scan tick.
    assign sum  = {1'b0, count} + (N+1)'(P);
    assign tick = sum[N];

    assign any_low = (rows_s != 4'hF);
    assign row_low = ~rows_s[row_idx];

    always_comb begin
        low_row = 2'd3;
        if (!rows_s[0])      low_row = 2'd0;
        else if (!rows_s[1]) low_row = 2'd1;
        else if (!rows_s[2]) low_row = 2'd2;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rows_m  <= 4'hF;
            rows_s  <= 4'hF;
            count   <= '0;
            state   <= SCAN;
            col_idx <= 2'd0;
            row_idx <= 2'd0;
            db_cnt  <= '0;
            key_r   <= 4'h0;
            kv_r    <= 1'b0;
        end else begin
            rows_m  <= kp.rows;
            rows_s  <= rows_m;
            count   <= sum[N-1:0];
            state   <= state_n;
            col_idx <= col_n;
            row_idx <= row_n;
            db_cnt  <= db_n;
            key_r   <= key_n;
            kv_r    <= kv_n;
        end
    end

    always_comb begin
        state_n = state;
        col_n   = col_idx;
        row_n   = row_idx;
        db_n    = db_cnt;
        key_n   = key_r;
        kv_n    = 1'b0;
        if (tick) begin
            case (state)
                SCAN: begin
                    if (any_low) begin
                        row_n   = low_row;
                        db_n    = '0;
                        state_n = DEBOUNCE;
                    end else begin
                        col_n = col_idx + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (row_low) begin
                        if (db_cnt == DB_LAST) begin
                            key_n   = key_map(row_idx, col_idx);
                            kv_n    = 1'b1;
                            state_n = HELD;
                        end else begin
                            db_n = db_cnt + DBW'(1);
                        end
                    end else begin
                        col_n   = col_idx + 2'd1;
                        state_n = SCAN;
                    end
                end
                HELD: begin
                    // Only the locked row matters; a second key is invisible until release.
                    if (!row_low) begin
                        db_n    = '0;
                        state_n = RELEASE;
                    end
                end
                RELEASE: begin
                    if (row_low) begin
                        db_n    = '0;
                        state_n = HELD;
                    end else if (db_cnt == DB_LAST) begin
                        col_n   = col_idx + 2'd1;
                        state_n = SCAN;
                    end else begin
                        db_n = db_cnt + DBW'(1);
                    end
                end
                default: state_n = SCAN;
            endcase
        end
    end

    assign kp.cols      = ~(4'b0001 << col_idx);
    assign kp.key       = key_r;
    assign kp.key_valid = kv_r;
    assign kp.pressed   = (state == HELD) || (state == RELEASE);

    a_one_col: assert property (@(posedge clk) disable iff (!rstn) $onehot(~kp.cols));
    a_kv_pulse: assert property (@(posedge clk) disable iff (!rstn) kv_r |=> !kv_r);

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with P=1, N=2 (tick every 4 clk), DB_TICKS=3.
// Latency: n/a. Backpressure: n/a; a matrix model drives rows from cols and the pressed-key mask.
module tb_keypad_scanner;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    keypad_scanner_if kp();

    keypad_scanner #(.P(1), .N(2), .DB_TICKS(3)) dut (
        .clk  (clk),
        .rstn (rstn),
        .kp   (kp)
    );

    // keys[r*4+c] = 1 means the key at row r, column c is held down
    logic [15:0] keys = '0;
    always_comb begin
        kp.rows = 4'hF;
        for (int r = 0; r < 4; r++)
            kp.rows[r] = ~|(keys[r*4 +: 4] & ~kp.cols);
    end

    int cyc;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    int         pulses = 0;
    int         dbl    = 0;
    logic [3:0] last_key = 4'h0;
    logic       prev_kv  = 1'b0;
    always @(negedge clk) begin
        if (kp.key_valid) begin
            pulses++;
            last_key = kp.key;
        end
        if (kp.key_valid && prev_kv) dbl++;
        prev_kv = kp.key_valid;
    end

    int tests = 0;
    int fails = 0;
    int base;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_pulse(input int b, input int maxc, input string tag);
        for (int i = 0; i < maxc && pulses == b; i++) step(1);
        step(4);
        check(tag, pulses - b, 1);
    endtask

    task automatic wait_release(input int maxc, input string tag);
        for (int i = 0; i < maxc && kp.pressed; i++) step(1);
        check(tag, {31'd0, kp.pressed}, 0);
    endtask

    initial begin
        #1 rstn = 1'b0;
        step(3);
        check("rst_cols",    {28'd0, kp.cols}, 32'hE);
        check("rst_key",     {28'd0, kp.key}, 0);
        check("rst_kv",      {31'd0, kp.key_valid}, 0);
        check("rst_pressed", {31'd0, kp.pressed}, 0);
        rstn = 1'b1;

        // 1: idle scan, one column per 4 clk
        step(3);  check("scan_c0", {28'd0, kp.cols}, 32'hE);
        step(1);  check("scan_c1", {28'd0, kp.cols}, 32'hD);
        step(4);  check("scan_c2", {28'd0, kp.cols}, 32'hB);
        step(4);  check("scan_c3", {28'd0, kp.cols}, 32'h7);
        step(4);  check("scan_wrap", {28'd0, kp.cols}, 32'hE);
        step(4);  check("idle_no_kv", pulses, 0);

        // 2: steady row1/col2 -> 6, release timed from a tick edge
        base = pulses;
        keys[6] = 1'b1;
        wait_pulse(base, 200, "k6_pulse");
        check("k6_key", {28'd0, last_key}, 32'h6);
        check("k6_pressed", {31'd0, kp.pressed}, 1);
        for (int i = 0; i < 4 && (cyc % 4) != 0; i++) step(1);
        keys = '0;
        step(15); check("k6_still_pressed", {31'd0, kp.pressed}, 1);
        step(1);  check("k6_released", {31'd0, kp.pressed}, 0);
        check("k6_resume_c3", {28'd0, kp.cols}, 32'h7);
        step(8);  check("k6_one_pulse", pulses - base, 1);

        // 3: bouncing row3/col1 then stable -> 0
        base = pulses;
        repeat (5) begin
            keys[13] = 1'b1; step(4);
            keys = '0;       step(4);
        end
        check("bounce_no_kv", pulses - base, 0);
        keys[13] = 1'b1;
        wait_pulse(base, 200, "k0_pulse");
        check("k0_key", {28'd0, last_key}, 32'h0);
        keys = '0;
        wait_release(60, "k0_release");

        // 4: hold 1, add C, release 1 -> C reported afterwards
        base = pulses;
        keys[0] = 1'b1;
        wait_pulse(base, 200, "k1_pulse");
        check("k1_key", {28'd0, last_key}, 32'h1);
        keys[11] = 1'b1;
        step(40); check("second_key_ignored", pulses - base, 1);
        keys[0] = 1'b0;
        wait_pulse(base + 1, 200, "kc_pulse");
        check("kc_key", {28'd0, last_key}, 32'hC);
        check("kc_pressed", {31'd0, kp.pressed}, 1);
        keys = '0;
        wait_release(60, "kc_release");

        // 5: two rows in col0 -> lowest row (4)
        base = pulses;
        keys[4] = 1'b1; keys[8] = 1'b1;
        wait_pulse(base, 200, "k4_pulse");
        check("k4_key", {28'd0, last_key}, 32'h4);
        step(40); check("k4_one_pulse", pulses - base, 1);
        keys = '0;
        wait_release(60, "k4_release");

        // 6a: reset while debouncing key 3 (row0/col2)
        for (int i = 0; i < 40 && !(kp.cols == 4'hB && (cyc % 4) == 0); i++) step(1);
        base = pulses;
        keys[2] = 1'b1;
        step(5);  check("db_col_locked", {28'd0, kp.cols}, 32'hB);
        step(1);
        rstn = 1'b0;
        #1;
        check("db_rst_cols", {28'd0, kp.cols}, 32'hE);
        check("db_rst_key",  {28'd0, kp.key}, 0);
        check("db_rst_kv",   {31'd0, kp.key_valid}, 0);
        keys = '0;
        step(2);
        rstn = 1'b1;
        step(40); check("db_rst_no_kv", pulses - base, 0);

        // 6b: reset while holding key 5 (row1/col1)
        base = pulses;
        keys[5] = 1'b1;
        wait_pulse(base, 200, "k5_pulse");
        check("k5_key", {28'd0, last_key}, 32'h5);
        check("k5_cols", {28'd0, kp.cols}, 32'hD);
        rstn = 1'b0;
        #1;
        check("held_rst_pressed", {31'd0, kp.pressed}, 0);
        check("held_rst_key",     {28'd0, kp.key}, 0);
        check("held_rst_cols",    {28'd0, kp.cols}, 32'hE);
        keys = '0;
        step(2);
        rstn = 1'b1;
        base = pulses;
        step(40); check("held_rst_no_kv", pulses - base, 0);

        check("kv_never_double", dbl, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
